// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: decides when the clock sounds (alarm, snooze re-ring, hourly
// chime) and drives the song player's play-enable and song-select.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | silent, watching for alarm / chime hits on each tick
// RING   | alarm sounding, auto-stops after RING_SECONDS ticks
// SNOOZE | silent, re-rings after SNOOZE_MINUTES*60 ticks
// CHIME  | hourly chime sounding for CHIME_SECONDS ticks

// Button conditioner: two-flop synchronizer, stable-time debounce, rising-edge pulse.
module alarm_btn_debounce #(
  parameter int DB_CYC = 4
) (
  input  logic sys_CLK,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int DB_W = $clog2(DB_CYC) + 1;

  logic            sync_a;
  logic            sync_b;
  logic            level;
  logic [DB_W-1:0] cnt;

  // Bring the raw button into the sys_CLK domain.
  always_ff @(posedge sys_CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after DB_CYC consecutive cycles; pulse on the 0->1 change.
  always_ff @(posedge sys_CLK or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DB_CYC - 1)) begin
        level <= sync_b;
        cnt   <= '0;
        press <= sync_b;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module alarm_ring_ctrl #(
  parameter int         CLK_HZ         = 100_000_000,
  parameter int         DEBOUNCE_MS    = 20,
  parameter int         RING_SECONDS   = 60,
  parameter int         SNOOZE_MINUTES = 5,
  parameter int         CHIME_SECONDS  = 4,
  parameter logic [1:0] CHIME_SONG     = 2'd1
) (
  input  logic       sys_CLK,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_en,
  input  logic       chime_en,
  input  logic [1:0] alarm_song,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  output logic       play,
  output logic [1:0] song_id,
  output logic       ringing,
  output logic       snoozing
);

  localparam int DB_CYC    = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int SNZ_TICKS = SNOOZE_MINUTES * 60;
  localparam int RING_W    = $clog2(RING_SECONDS) + 1;
  localparam int SNZ_W     = $clog2(SNZ_TICKS) + 1;
  localparam int CHM_W     = $clog2(CHIME_SECONDS) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2,
    S_CHIME  = 2'd3
  } state_t;

  state_t            state;
  logic [RING_W-1:0] ring_cnt;
  logic [SNZ_W-1:0]  snz_cnt;
  logic [CHM_W-1:0]  chm_cnt;
  logic              press_stop;
  logic              press_snooze;
  logic              alarm_hit;
  logic              chime_hit;

  alarm_btn_debounce #(.DB_CYC(DB_CYC)) u_db_stop (
    .sys_CLK (sys_CLK),
    .rst_n   (rst_n),
    .btn_raw (btn_stop),
    .press   (press_stop)
  );

  alarm_btn_debounce #(.DB_CYC(DB_CYC)) u_db_snooze (
    .sys_CLK (sys_CLK),
    .rst_n   (rst_n),
    .btn_raw (btn_snooze),
    .press   (press_snooze)
  );

  // Time-of-day events, only meaningful in the tick cycle.
  always_comb begin
    alarm_hit = tick_1hz & alarm_en & (cur_sec == 6'd0) &
                (cur_hour == alarm_hour) & (cur_min == alarm_min);
    chime_hit = tick_1hz & chime_en & (cur_sec == 6'd0) & (cur_min == 6'd0);
  end

  // Sequencer; outputs are registered alongside the state they decode.
  // Timers are down-counters loaded on entry and ending at a count of one,
  // so the terminal tick is the RING_SECONDS-th / SNZ_TICKS-th / CHIME_SECONDS-th.
  // A press outranks a tick arriving in the same cycle.
  always_ff @(posedge sys_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      chm_cnt  <= '0;
      play     <= 1'b0;
      song_id  <= 2'd0;
      ringing  <= 1'b0;
      snoozing <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (alarm_hit) begin
            state    <= S_RING;
            ring_cnt <= RING_W'(RING_SECONDS);
            song_id  <= alarm_song;
            play     <= 1'b1;
            ringing  <= 1'b1;
            snoozing <= 1'b0;
          end else if (chime_hit) begin
            state    <= S_CHIME;
            chm_cnt  <= CHM_W'(CHIME_SECONDS);
            song_id  <= CHIME_SONG;
            play     <= 1'b1;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
          end
        end

        S_RING: begin
          if (press_stop) begin
            state    <= S_IDLE;
            play     <= 1'b0;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
          end else if (press_snooze) begin
            state    <= S_SNOOZE;
            snz_cnt  <= SNZ_W'(SNZ_TICKS);
            play     <= 1'b0;
            ringing  <= 1'b0;
            snoozing <= 1'b1;
          end else if (tick_1hz) begin
            if (ring_cnt == RING_W'(1)) begin
              state    <= S_IDLE;
              play     <= 1'b0;
              ringing  <= 1'b0;
              snoozing <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt - 1'b1;
            end
          end
        end

        S_SNOOZE: begin
          if (press_stop || !alarm_en) begin
            state    <= S_IDLE;
            play     <= 1'b0;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
          end else if (tick_1hz) begin
            if (snz_cnt == SNZ_W'(1)) begin
              state    <= S_RING;
              ring_cnt <= RING_W'(RING_SECONDS);
              song_id  <= alarm_song;
              play     <= 1'b1;
              ringing  <= 1'b1;
              snoozing <= 1'b0;
            end else begin
              snz_cnt <= snz_cnt - 1'b1;
            end
          end
        end

        S_CHIME: begin
          if (press_stop || press_snooze) begin
            state    <= S_IDLE;
            play     <= 1'b0;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
          end else if (alarm_hit) begin
            state    <= S_RING;
            ring_cnt <= RING_W'(RING_SECONDS);
            song_id  <= alarm_song;
            play     <= 1'b1;
            ringing  <= 1'b1;
            snoozing <= 1'b0;
          end else if (tick_1hz) begin
            if (chm_cnt == CHM_W'(1)) begin
              state    <= S_IDLE;
              play     <= 1'b0;
              ringing  <= 1'b0;
              snoozing <= 1'b0;
            end else begin
              chm_cnt <= chm_cnt - 1'b1;
            end
          end
        end

        default: begin
          state    <= S_IDLE;
          play     <= 1'b0;
          ringing  <= 1'b0;
          snoozing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Bench for alarm_ring_ctrl with DB_CYC=4, RING_SECONDS=3, SNOOZE_MINUTES=1.
module tb_alarm_ring_ctrl;

  logic       sys_CLK = 1'b0;
  logic       rst_n;
  logic       tick_1hz;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_en;
  logic       chime_en;
  logic [1:0] alarm_song;
  logic       btn_stop;
  logic       btn_snooze;
  logic       play;
  logic [1:0] song_id;
  logic       ringing;
  logic       snoozing;

  int n_vec = 0;
  int n_err = 0;

  alarm_ring_ctrl #(
    .CLK_HZ         (4000),
    .DEBOUNCE_MS    (1),
    .RING_SECONDS   (3),
    .SNOOZE_MINUTES (1),
    .CHIME_SECONDS  (4),
    .CHIME_SONG     (2'd1)
  ) dut (
    .sys_CLK    (sys_CLK),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .alarm_en   (alarm_en),
    .chime_en   (chime_en),
    .alarm_song (alarm_song),
    .btn_stop   (btn_stop),
    .btn_snooze (btn_snooze),
    .play       (play),
    .song_id    (song_id),
    .ringing    (ringing),
    .snoozing   (snoozing)
  );

  always #5 sys_CLK = ~sys_CLK;

  typedef struct {
    logic       tk;
    logic [4:0] hr;
    logic [5:0] mn;
    logic [5:0] sc;
    logic [4:0] ah;
    logic [5:0] am;
    logic       ae;
    logic       ce;
    logic [1:0] as;
    logic [4:0] exp;   // {play, song_id, ringing, snoozing}
  } vec_t;

  vec_t vq[$];

  task automatic addv(input int tk, input int hr, input int mn, input int sc,
                      input int ah, input int am, input int ae, input int ce,
                      input int as, input int ep, input int es, input int er,
                      input int ez);
    vec_t v;
    v.tk  = 1'(tk);
    v.hr  = 5'(hr);
    v.mn  = 6'(mn);
    v.sc  = 6'(sc);
    v.ah  = 5'(ah);
    v.am  = 6'(am);
    v.ae  = 1'(ae);
    v.ce  = 1'(ce);
    v.as  = 2'(as);
    v.exp = {1'(ep), 2'(es), 1'(er), 1'(ez)};
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge sys_CLK);
    #1;
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    step();
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = {play, song_id, ringing, snoozing};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: play/song/ring/snz got %b required %b", name, got, exp);
    end
  endtask

  // Hold buttons 4 cycles, then check the cycle carrying the press pulse and the cycle after.
  task automatic press_seq(input logic s, input logic z, input string name,
                           input logic [4:0] exp_pre, input logic [4:0] exp_post);
    btn_stop   = s;
    btn_snooze = z;
    repeat (4) step();
    btn_stop   = 1'b0;
    btn_snooze = 1'b0;
    step();
    step();
    check({name, "_pulse_cycle"}, exp_pre);
    step();
    check(name, exp_post);
    repeat (8) step();
  endtask

  initial begin
    rst_n      = 1'b0;
    tick_1hz   = 1'b0;
    cur_hour   = 5'd0;
    cur_min    = 6'd0;
    cur_sec    = 6'd0;
    alarm_hour = 5'd0;
    alarm_min  = 6'd0;
    alarm_en   = 1'b0;
    chime_en   = 1'b0;
    alarm_song = 2'd0;
    btn_stop   = 1'b0;
    btn_snooze = 1'b0;

    //    tk hr mn sc  ah am ae ce as   play song ring snz
    addv(0, 7, 29, 59, 7, 30, 1, 0, 2,  0, 0, 0, 0);
    addv(0, 7, 30,  0, 7, 30, 1, 0, 2,  0, 0, 0, 0);  // match but no tick
    addv(1, 7, 30,  1, 7, 30, 1, 0, 2,  0, 0, 0, 0);  // sec != 0
    addv(1, 7, 30,  0, 7, 30, 1, 0, 2,  1, 2, 1, 0);  // alarm hit
    addv(0, 7, 30,  0, 7, 30, 1, 0, 2,  1, 2, 1, 0);
    addv(1, 7, 30,  0, 7, 30, 1, 0, 3,  1, 2, 1, 0);  // hit ignored in RING; song held
    addv(1, 7, 30,  1, 7, 30, 1, 0, 3,  1, 2, 1, 0);
    addv(1, 7, 30,  2, 7, 30, 1, 0, 3,  0, 2, 0, 0);  // 3rd tick: auto-stop
    addv(1, 7, 30,  0, 7, 30, 0, 0, 3,  0, 2, 0, 0);  // alarm disarmed
    addv(1, 8,  0,  0, 7, 30, 0, 0, 3,  0, 2, 0, 0);  // chime disabled
    addv(1, 8,  0,  0, 7, 30, 0, 1, 3,  1, 1, 0, 0);  // chime
    addv(1, 8,  0,  1, 7, 30, 0, 1, 3,  1, 1, 0, 0);
    addv(1, 8,  0,  2, 7, 30, 0, 1, 3,  1, 1, 0, 0);
    addv(0, 8,  0,  2, 7, 30, 0, 1, 3,  1, 1, 0, 0);
    addv(1, 8,  0,  3, 7, 30, 0, 1, 3,  1, 1, 0, 0);
    addv(1, 8,  0,  4, 7, 30, 0, 1, 3,  0, 1, 0, 0);  // 4th chime tick ends it
    addv(1, 8,  0,  0, 8,  0, 1, 1, 3,  1, 3, 1, 0);  // tie: alarm wins
    addv(1, 8,  0,  1, 8,  0, 1, 1, 3,  1, 3, 1, 0);
    addv(1, 8,  0,  2, 8,  0, 1, 1, 3,  1, 3, 1, 0);
    addv(1, 8,  0,  3, 8,  0, 1, 1, 3,  0, 3, 0, 0);
    addv(1, 9,  0,  0, 9,  1, 1, 1, 2,  1, 1, 0, 0);  // chime
    addv(1, 9,  1,  0, 9,  1, 1, 1, 2,  1, 2, 1, 0);  // alarm pre-empts chime
    addv(1, 9,  1,  1, 9,  1, 1, 1, 2,  1, 2, 1, 0);
    addv(1, 9,  1,  2, 9,  1, 1, 1, 2,  1, 2, 1, 0);
    addv(1, 9,  1,  3, 9,  1, 1, 1, 2,  0, 2, 0, 0);
    addv(1, 10, 0,  5, 9,  1, 0, 1, 2,  0, 2, 0, 0);  // min==0 but sec!=0

    repeat (3) step();
    check("reset_state", 5'b0_00_0_0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < vq.size(); i++) begin
      tick_1hz   = vq[i].tk;
      cur_hour   = vq[i].hr;
      cur_min    = vq[i].mn;
      cur_sec    = vq[i].sc;
      alarm_hour = vq[i].ah;
      alarm_min  = vq[i].am;
      alarm_en   = vq[i].ae;
      chime_en   = vq[i].ce;
      alarm_song = vq[i].as;
      step();
      check($sformatf("vec%0d", i), vq[i].exp);
    end
    tick_1hz = 1'b0;

    // Snooze, re-ring after 60 ticks with fresh ring count and new song, then stop.
    alarm_hour = 5'd7; alarm_min = 6'd30; alarm_en = 1'b1; chime_en = 1'b0;
    alarm_song = 2'd2; cur_hour = 5'd7; cur_min = 6'd30; cur_sec = 6'd0;
    do_tick();
    check("ring_b", 5'b1_10_1_0);
    cur_sec = 6'd30;
    do_tick();
    press_seq(1'b0, 1'b1, "snooze_entry", 5'b1_10_1_0, 5'b0_10_0_1);
    alarm_song = 2'd1;
    repeat (59) do_tick();
    check("snooze_59_ticks", 5'b0_10_0_1);
    do_tick();
    check("rering_60th_tick", 5'b1_01_1_0);
    do_tick();
    do_tick();
    check("ring_cnt_cleared", 5'b1_01_1_0);
    press_seq(1'b1, 1'b0, "stop_ring", 5'b1_01_1_0, 5'b0_01_0_0);

    // Glitch rejected; stop and snooze together -> IDLE.
    cur_sec = 6'd0;
    do_tick();
    check("ring_c", 5'b1_01_1_0);
    btn_stop = 1'b1;
    step();
    step();
    btn_stop = 1'b0;
    repeat (10) step();
    check("glitch_ignored", 5'b1_01_1_0);
    press_seq(1'b1, 1'b1, "stop_wins", 5'b1_01_1_0, 5'b0_01_0_0);

    // Snooze press and terminal ring tick in the same cycle: press wins.
    cur_sec = 6'd0;
    do_tick();
    cur_sec = 6'd1;
    do_tick();
    do_tick();
    check("ring_cnt_one", 5'b1_01_1_0);
    btn_snooze = 1'b1;
    repeat (4) step();
    btn_snooze = 1'b0;
    step();
    step();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    check("press_beats_tick", 5'b0_01_0_1);
    repeat (8) step();
    press_seq(1'b1, 1'b0, "stop_in_snooze", 5'b0_01_0_1, 5'b0_01_0_0);

    // Alarm disarmed during snooze -> IDLE, no re-ring.
    alarm_song = 2'd2; cur_sec = 6'd0;
    do_tick();
    check("ring_d", 5'b1_10_1_0);
    press_seq(1'b0, 1'b1, "snooze_d", 5'b1_10_1_0, 5'b0_10_0_1);
    alarm_en = 1'b0;
    step();
    check("alarm_off_in_snooze", 5'b0_10_0_0);
    cur_sec = 6'd1;
    repeat (60) do_tick();
    check("no_rering", 5'b0_10_0_0);

    // Chime cut short by snooze button.
    cur_hour = 5'd11; cur_min = 6'd0; cur_sec = 6'd0; chime_en = 1'b1;
    do_tick();
    check("chime_e", 5'b1_01_0_0);
    press_seq(1'b0, 1'b1, "chime_stop", 5'b1_01_0_0, 5'b0_01_0_0);

    // Asynchronous reset while ringing.
    chime_en = 1'b0; alarm_en = 1'b1; alarm_song = 2'd3;
    cur_hour = 5'd7; cur_min = 6'd30; cur_sec = 6'd0;
    do_tick();
    check("ring_f", 5'b1_11_1_0);
    @(posedge sys_CLK);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 5'b0_00_0_0);
    repeat (2) step();
    rst_n = 1'b1;
    cur_sec = 6'd1;
    repeat (5) do_tick();
    check("idle_after_reset", 5'b0_00_0_0);
    cur_sec = 6'd0;
    do_tick();
    check("ring_after_reset", 5'b1_11_1_0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
